// File: rtl/id_stage_hazard_pipe.sv
// ARM decode stage: field decode, register file, condition check, RAW hazard detection
// and the ID/EX pipeline register with flush/freeze/valid tracking.
module id_stage_hazard_pipe #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned REG_COUNT  = 16,
  parameter int unsigned FORWARD_EN = 0,
  parameter int unsigned RF_BYPASS  = 1,
  localparam int unsigned RA        = $clog2(REG_COUNT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  freeze,
  input  logic                  valid_in,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  input  logic [31:0]           instruction,
  input  logic [3:0]            sr,
  input  logic                  wb_en_in,
  input  logic [RA-1:0]         wb_dest,
  input  logic [DATA_WIDTH-1:0] wb_result,
  input  logic                  ex_wb_en,
  input  logic                  ex_mem_r_en,
  input  logic [RA-1:0]         ex_dest,
  input  logic                  mem_wb_en,
  input  logic [RA-1:0]         mem_dest,
  output logic                  hazard_stall,
  output logic                  valid_out,
  output logic                  wb_en_out,
  output logic                  mem_r_en,
  output logic                  mem_w_en,
  output logic                  b,
  output logic                  s,
  output logic                  imm,
  output logic [3:0]            exec_cmd,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic [DATA_WIDTH-1:0] val_r_n,
  output logic [DATA_WIDTH-1:0] val_r_m,
  output logic [11:0]           shift_operand,
  output logic [23:0]           signed_imm_24,
  output logic [RA-1:0]         dest,
  output logic [RA-1:0]         src_1,
  output logic [RA-1:0]         src_2
);

  logic [3:0]            w_cond, w_op;
  logic [1:0]            w_mode;
  logic                  w_i, w_sbit, w_cond_ok;
  logic [RA-1:0]         w_rn, w_rd, w_src_2;
  logic [DATA_WIDTH-1:0] w_val_n, w_val_m;
  logic [3:0]            w_cmd;
  logic                  w_wb_en, w_mem_r, w_mem_w, w_b, w_s, w_imm;
  logic                  w_use_1, w_use_2, w_hit_ex, w_hit_mem, w_hazard, w_issue;

  logic [DATA_WIDTH-1:0] r_rf [REG_COUNT];

  logic                  r_valid, r_wb_en, r_mem_r, r_mem_w, r_b, r_s, r_imm;
  logic [3:0]            r_cmd;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_val_n, r_val_m;
  logic [11:0]           r_shop;
  logic [23:0]           r_simm;
  logic [RA-1:0]         r_dest, r_src_1, r_src_2;

  assign w_cond  = instruction[31:28];
  assign w_mode  = instruction[27:26];
  assign w_i     = instruction[25];
  assign w_op    = instruction[24:21];
  assign w_sbit  = instruction[20];
  assign w_rn    = RA'(instruction[19:16]);
  assign w_rd    = RA'(instruction[15:12]);
  // STR reads its store data from Rd.
  assign w_src_2 = (w_mode == 2'b01 && !w_sbit) ? w_rd : RA'(instruction[3:0]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < REG_COUNT; k++) r_rf[k] <= '0;
    end else if (wb_en_in) begin
      r_rf[wb_dest] <= wb_result;
    end
  end

  assign w_val_n = (RF_BYPASS != 0 && wb_en_in && wb_dest == w_rn)    ? wb_result : r_rf[w_rn];
  assign w_val_m = (RF_BYPASS != 0 && wb_en_in && wb_dest == w_src_2) ? wb_result : r_rf[w_src_2];

  // sr = {N,Z,C,V}
  always_comb begin
    w_cond_ok = 1'b0;
    case (w_cond)
      4'b0000: w_cond_ok = sr[2];
      4'b0001: w_cond_ok = !sr[2];
      4'b0010: w_cond_ok = sr[1];
      4'b0011: w_cond_ok = !sr[1];
      4'b0100: w_cond_ok = sr[3];
      4'b0101: w_cond_ok = !sr[3];
      4'b0110: w_cond_ok = sr[0];
      4'b0111: w_cond_ok = !sr[0];
      4'b1000: w_cond_ok = sr[1] && !sr[2];
      4'b1001: w_cond_ok = !sr[1] || sr[2];
      4'b1010: w_cond_ok = (sr[3] == sr[0]);
      4'b1011: w_cond_ok = (sr[3] != sr[0]);
      4'b1100: w_cond_ok = !sr[2] && (sr[3] == sr[0]);
      4'b1101: w_cond_ok = sr[2] || (sr[3] != sr[0]);
      4'b1110: w_cond_ok = 1'b1;
      default: w_cond_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_cmd   = '0;
    w_wb_en = 1'b0;
    w_mem_r = 1'b0;
    w_mem_w = 1'b0;
    w_b     = 1'b0;
    w_s     = 1'b0;
    w_imm   = 1'b0;
    unique case (w_mode)
      2'b00: begin
        w_imm   = w_i;
        w_s     = w_sbit;
        w_wb_en = 1'b1;
        unique case (w_op)
          4'b1101: w_cmd = 4'b0001;
          4'b1111: w_cmd = 4'b1001;
          4'b0100: w_cmd = 4'b0010;
          4'b0101: w_cmd = 4'b0011;
          4'b0010: w_cmd = 4'b0100;
          4'b0110: w_cmd = 4'b0101;
          4'b0000: w_cmd = 4'b0110;
          4'b1100: w_cmd = 4'b0111;
          4'b0001: w_cmd = 4'b1000;
          4'b1010: begin
            w_cmd   = 4'b0100;
            w_wb_en = 1'b0;
          end
          4'b1000: begin
            w_cmd   = 4'b0110;
            w_wb_en = 1'b0;
          end
          default: begin
            w_imm   = 1'b0;
            w_s     = 1'b0;
            w_wb_en = 1'b0;
          end
        endcase
      end
      2'b01: begin
        w_cmd   = 4'b0010;
        w_imm   = w_i;
        w_mem_r = w_sbit;
        w_wb_en = w_sbit;
        w_mem_w = !w_sbit;
      end
      2'b10:   w_b = 1'b1;
      default: ;
    endcase
    if (!w_cond_ok) begin
      w_wb_en = 1'b0;
      w_mem_r = 1'b0;
      w_mem_w = 1'b0;
      w_b     = 1'b0;
      w_s     = 1'b0;
    end
  end

  // MOV/MVN ignore Rn; branches read nothing.
  assign w_use_1   = (w_mode == 2'b00 && w_op != 4'b1101 && w_op != 4'b1111) || w_mode == 2'b01;
  assign w_use_2   = (w_mode == 2'b00 && !w_i) || (w_mode == 2'b01 && !w_sbit);
  assign w_hit_ex  = (w_use_1 && w_rn == ex_dest) || (w_use_2 && w_src_2 == ex_dest);
  assign w_hit_mem = (w_use_1 && w_rn == mem_dest) || (w_use_2 && w_src_2 == mem_dest);
  assign w_hazard  = (FORWARD_EN != 0) ? (valid_in && ex_mem_r_en && w_hit_ex)
                   : (valid_in && ((ex_wb_en && w_hit_ex) || (mem_wb_en && w_hit_mem)));
  assign w_issue   = valid_in && !flush && !w_hazard;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_wb_en <= 1'b0;
      r_mem_r <= 1'b0;
      r_mem_w <= 1'b0;
      r_b     <= 1'b0;
      r_s     <= 1'b0;
      r_imm   <= 1'b0;
      r_cmd   <= '0;
      r_pc    <= '0;
      r_val_n <= '0;
      r_val_m <= '0;
      r_shop  <= '0;
      r_simm  <= '0;
      r_dest  <= '0;
      r_src_1 <= '0;
      r_src_2 <= '0;
    end else if (!freeze) begin
      r_valid <= w_issue;
      r_wb_en <= w_issue && w_wb_en;
      r_mem_r <= w_issue && w_mem_r;
      r_mem_w <= w_issue && w_mem_w;
      r_b     <= w_issue && w_b;
      r_s     <= w_issue && w_s;
      r_imm   <= w_issue && w_imm;
      r_cmd   <= w_issue ? w_cmd : 4'b0000;
      r_pc    <= pc_in;
      r_val_n <= w_val_n;
      r_val_m <= w_val_m;
      r_shop  <= instruction[11:0];
      r_simm  <= instruction[23:0];
      r_dest  <= w_rd;
      r_src_1 <= w_rn;
      r_src_2 <= w_src_2;
    end
  end

  assign hazard_stall  = w_hazard;
  assign valid_out     = r_valid;
  assign wb_en_out     = r_wb_en;
  assign mem_r_en      = r_mem_r;
  assign mem_w_en      = r_mem_w;
  assign b             = r_b;
  assign s             = r_s;
  assign imm           = r_imm;
  assign exec_cmd      = r_cmd;
  assign pc_out        = r_pc;
  assign val_r_n       = r_val_n;
  assign val_r_m       = r_val_m;
  assign shift_operand = r_shop;
  assign signed_imm_24 = r_simm;
  assign dest          = r_dest;
  assign src_1         = r_src_1;
  assign src_2         = r_src_2;

endmodule

// File: tb/tb_id_stage_hazard_pipe.sv
// Bench for id_stage_hazard_pipe: two instances (stall-all + bypass, load-use-only + no bypass)
// checked every cycle against a behavioural model, plus directed literal checks.
module tb_id_stage_hazard_pipe;

  typedef struct packed {
    logic        valid, wb_en, mem_r, mem_w, b, s, imm;
    logic [3:0]  cmd;
    logic [31:0] pc, vrn, vrm;
    logic [11:0] shop;
    logic [23:0] simm;
    logic [3:0]  dest, src1, src2;
  } outs_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0, freeze = 1'b0, valid_in = 1'b0;
  logic [31:0] pc_in = '0, instruction = '0, wb_result = '0;
  logic [3:0]  sr = '0, wb_dest = '0, ex_dest = '0, mem_dest = '0;
  logic        wb_en_in = 1'b0, ex_wb_en = 1'b0, ex_mem_r_en = 1'b0, mem_wb_en = 1'b0;

  wire outs_t act0, act1;
  wire        hz0, hz1;

  int n_checks = 0;
  int n_errors = 0;

  outs_t       exp0 = '0;
  outs_t       exp1 = '0;
  logic [31:0] m_rf [16] = '{default: '0};
  int          dp_cmd [16] = '{6, 8, 4, -1, 2, 3, 5, -1, 6, -1, 4, -1, 7, 1, -1, 9};

  always #5 clk = ~clk;

  id_stage_hazard_pipe #(.FORWARD_EN(0), .RF_BYPASS(1)) u_dut0 (
    .clk(clk), .rst(rst), .flush(flush), .freeze(freeze), .valid_in(valid_in), .pc_in(pc_in),
    .instruction(instruction), .sr(sr), .wb_en_in(wb_en_in), .wb_dest(wb_dest),
    .wb_result(wb_result), .ex_wb_en(ex_wb_en), .ex_mem_r_en(ex_mem_r_en), .ex_dest(ex_dest),
    .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .hazard_stall(hz0), .valid_out(act0.valid),
    .wb_en_out(act0.wb_en), .mem_r_en(act0.mem_r), .mem_w_en(act0.mem_w), .b(act0.b),
    .s(act0.s), .imm(act0.imm), .exec_cmd(act0.cmd), .pc_out(act0.pc), .val_r_n(act0.vrn),
    .val_r_m(act0.vrm), .shift_operand(act0.shop), .signed_imm_24(act0.simm),
    .dest(act0.dest), .src_1(act0.src1), .src_2(act0.src2)
  );

  id_stage_hazard_pipe #(.FORWARD_EN(1), .RF_BYPASS(0)) u_dut1 (
    .clk(clk), .rst(rst), .flush(flush), .freeze(freeze), .valid_in(valid_in), .pc_in(pc_in),
    .instruction(instruction), .sr(sr), .wb_en_in(wb_en_in), .wb_dest(wb_dest),
    .wb_result(wb_result), .ex_wb_en(ex_wb_en), .ex_mem_r_en(ex_mem_r_en), .ex_dest(ex_dest),
    .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .hazard_stall(hz1), .valid_out(act1.valid),
    .wb_en_out(act1.wb_en), .mem_r_en(act1.mem_r), .mem_w_en(act1.mem_w), .b(act1.b),
    .s(act1.s), .imm(act1.imm), .exec_cmd(act1.cmd), .pc_out(act1.pc), .val_r_n(act1.vrn),
    .val_r_m(act1.vrm), .shift_operand(act1.shop), .signed_imm_24(act1.simm),
    .dest(act1.dest), .src_1(act1.src1), .src_2(act1.src2)
  );

  // ---------------- behavioural model ----------------
  // Odd condition codes are the negation of the even one below them; AL negated is "never".
  function automatic bit cond_pass(logic [3:0] c, logic [3:0] f);
    bit n = f[3], z = f[2], cy = f[1], v = f[0];
    bit base;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return base ^ c[0];
  endfunction

  function automatic logic [31:0] rd_rf(logic [3:0] idx, bit byp);
    if (byp && wb_en_in && wb_dest == idx) return wb_result;
    return m_rf[idx];
  endfunction

  function automatic bit model_hazard(bit fwd);
    logic [1:0] mode = instruction[27:26];
    logic [3:0] opc  = instruction[24:21];
    logic [3:0] rn   = instruction[19:16];
    logic [3:0] r2   = (mode == 2'd1 && !instruction[20]) ? instruction[15:12] : instruction[3:0];
    bit u1 = (mode == 2'd0 && opc != 4'd13 && opc != 4'd15) || mode == 2'd1;
    bit u2 = (mode == 2'd0 && !instruction[25]) || (mode == 2'd1 && !instruction[20]);
    bit on_ex  = (u1 && rn == ex_dest)  || (u2 && r2 == ex_dest);
    bit on_mem = (u1 && rn == mem_dest) || (u2 && r2 == mem_dest);
    if (!valid_in) return 1'b0;
    if (fwd) return ex_mem_r_en && on_ex;
    return (ex_wb_en && on_ex) || (mem_wb_en && on_mem);
  endfunction

  function automatic outs_t model_decode(bit byp);
    outs_t      d = '0;
    logic [1:0] mode = instruction[27:26];
    logic [3:0] opc  = instruction[24:21];
    bit         sb   = instruction[20];
    d.valid = 1'b1;
    d.pc    = pc_in;
    d.shop  = instruction[11:0];
    d.simm  = instruction[23:0];
    d.dest  = instruction[15:12];
    d.src1  = instruction[19:16];
    d.src2  = (mode == 2'd1 && !sb) ? instruction[15:12] : instruction[3:0];
    d.vrn   = rd_rf(d.src1, byp);
    d.vrm   = rd_rf(d.src2, byp);
    if (mode == 2'd0 && dp_cmd[opc] >= 0) begin
      d.cmd   = 4'(dp_cmd[opc]);
      d.wb_en = !(opc == 4'd10 || opc == 4'd8);
      d.s     = sb;
      d.imm   = instruction[25];
    end else if (mode == 2'd1) begin
      d.cmd   = 4'd2;
      d.imm   = instruction[25];
      d.mem_r = sb;
      d.wb_en = sb;
      d.mem_w = !sb;
    end else if (mode == 2'd2) begin
      d.b = 1'b1;
    end
    if (!cond_pass(instruction[31:28], sr)) begin
      d.wb_en = 0; d.mem_r = 0; d.mem_w = 0; d.b = 0; d.s = 0;
    end
    return d;
  endfunction

  function automatic outs_t next_state(outs_t cur, bit fwd, bit byp);
    outs_t d;
    if (freeze) return cur;
    d = model_decode(byp);
    if (flush || !valid_in || model_hazard(fwd)) begin
      d.valid = 0; d.wb_en = 0; d.mem_r = 0; d.mem_w = 0; d.b = 0; d.s = 0; d.imm = 0;
      d.cmd = '0;
    end
    return d;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      exp0 = next_state(exp0, 1'b0, 1'b1);
      exp1 = next_state(exp1, 1'b1, 1'b0);
      if (wb_en_in) m_rf[wb_dest] = wb_result;
    end
  end

  always @(negedge rst) begin
    exp0 = '0;
    exp1 = '0;
    for (int k = 0; k < 16; k++) m_rf[k] = '0;
  end

  // ---------------- compare process ----------------
  task automatic chk_out(int id, outs_t a, outs_t e);
    n_checks++;
    if (a !== e) begin
      n_errors++;
      $display("FAIL idex_dut%0d at %0t: got %h required %h", id, $time, a, e);
    end
  endtask

  task automatic chk_bit(string name, logic a, logic e);
    n_checks++;
    if (a !== e) begin
      n_errors++;
      $display("FAIL %s at %0t: got %b required %b", name, $time, a, e);
    end
  endtask

  always @(negedge clk) begin
    chk_out(0, act0, exp0);
    chk_out(1, act1, exp1);
    chk_bit("hazard_dut0", hz0, model_hazard(1'b0));
    chk_bit("hazard_dut1", hz1, model_hazard(1'b1));
  end

  // ---------------- directed literal checks ----------------
  task automatic check_lit(string name, logic [31:0] a, logic [31:0] e);
    n_checks++;
    if (a !== e) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h required %h", name, $time, a, e);
    end
  endtask

  task automatic drive_slot();
    @(posedge clk);
    #2;
  endtask

  task automatic capture();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  localparam logic [31:0] AddR1R2R3  = 32'hE082_1003;
  localparam logic [31:0] SubR4R1I1  = 32'hE241_4001;
  localparam logic [31:0] MoveqR0I3  = 32'h03A0_0003;

  initial begin
    logic [3:0] rc, rn, rd, rm, op;
    logic [1:0] md;
    int         r;

    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check_lit("reset_valid", 32'(act0.valid), 0);
    check_lit("reset_pc", act0.pc, 0);
    drive_slot();
    rst = 1'b1;
    wb_en_in = 1'b1; wb_dest = 4'd2; wb_result = 32'd5;
    drive_slot();
    wb_dest = 4'd3; wb_result = 32'd7;
    drive_slot();
    wb_en_in = 1'b0;
    sr = 4'b0000;
    valid_in = 1'b1; pc_in = 32'h100; instruction = AddR1R2R3;
    capture();
    check_lit("add_valid", 32'(act0.valid), 1);
    check_lit("add_cmd", 32'(act0.cmd), 32'b0010);
    check_lit("add_vrn", act0.vrn, 5);
    check_lit("add_vrm", act0.vrm, 7);
    check_lit("add_dest", 32'(act0.dest), 1);
    check_lit("add_wb_en", 32'(act0.wb_en), 1);

    drive_slot();
    instruction = SubR4R1I1; ex_dest = 4'd1; ex_wb_en = 1'b1; ex_mem_r_en = 1'b0;
    #1;
    check_lit("sub_stall_fwd0", 32'(hz0), 1);
    check_lit("sub_nostall_fwd1", 32'(hz1), 0);
    capture();
    check_lit("sub_bubble_fwd0", 32'(act0.valid), 0);
    check_lit("sub_issue_fwd1", 32'(act1.cmd), 32'b0100);
    drive_slot();
    ex_mem_r_en = 1'b1;
    #1;
    check_lit("sub_loaduse_fwd1", 32'(hz1), 1);
    capture();
    check_lit("sub_bubble_fwd1", 32'(act1.valid), 0);
    drive_slot();
    ex_wb_en = 1'b0; ex_mem_r_en = 1'b0;
    capture();
    check_lit("sub_issue_fwd0", 32'(act0.valid), 1);
    check_lit("sub_cmd_fwd0", 32'(act0.cmd), 32'b0100);

    drive_slot();
    instruction = MoveqR0I3; sr = 4'b0000;
    capture();
    check_lit("moveq_fail_valid", 32'(act0.valid), 1);
    check_lit("moveq_fail_wb", 32'(act0.wb_en), 0);
    drive_slot();
    sr = 4'b0100;
    capture();
    check_lit("moveq_pass_wb", 32'(act0.wb_en), 1);

    drive_slot();
    freeze = 1'b1; flush = 1'b1; instruction = AddR1R2R3;
    for (int i = 0; i < 2; i++) begin
      capture();
      check_lit("freeze_valid", 32'(act0.valid), 1);
      check_lit("freeze_cmd", 32'(act0.cmd), 32'b0001);
    end
    drive_slot();
    freeze = 1'b0;
    capture();
    check_lit("flush_valid", 32'(act0.valid), 0);

    drive_slot();
    flush = 1'b0; wb_en_in = 1'b1; wb_dest = 4'd2; wb_result = 32'hDEAD;
    capture();
    check_lit("bypass_vrn", act0.vrn, 32'hDEAD);
    check_lit("nobypass_vrn", act1.vrn, 5);
    drive_slot();
    wb_en_in = 1'b0;
    drive_slot();
    rst = 1'b0;
    #1;
    check_lit("midreset_valid", 32'(act0.valid), 0);
    check_lit("midreset_vrn", act0.vrn, 0);
    drive_slot();
    rst = 1'b1;
    capture();
    check_lit("rf_cleared", act0.vrn, 0);

    for (int c = 0; c < 3000; c++) begin
      drive_slot();
      if (!rst) rst = 1'b1;
      else if ($urandom_range(0, 199) == 0) rst = 1'b0;
      r  = $urandom_range(0, 9);
      md = (r < 6) ? 2'd0 : (r < 8) ? 2'd1 : (r == 8) ? 2'd2 : 2'd3;
      rc = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd14;
      op = 4'($urandom_range(0, 15));
      rn = 4'($urandom_range(0, 4));
      rd = 4'($urandom_range(0, 4));
      rm = 4'($urandom_range(0, 4));
      instruction = {rc, md, 1'($urandom_range(0, 1)), op, 1'($urandom_range(0, 1)), rn, rd,
                     8'($urandom), rm};
      valid_in    = ($urandom_range(0, 9) != 0);
      pc_in       = $urandom;
      sr          = 4'($urandom);
      flush       = ($urandom_range(0, 9) == 0);
      freeze      = ($urandom_range(0, 7) == 0);
      wb_en_in    = 1'($urandom_range(0, 1));
      wb_dest     = 4'($urandom_range(0, 4));
      wb_result   = $urandom;
      ex_wb_en    = 1'($urandom_range(0, 1));
      ex_mem_r_en = 1'($urandom_range(0, 1));
      mem_wb_en   = 1'($urandom_range(0, 1));
      ex_dest     = 4'($urandom_range(0, 4));
      mem_dest    = 4'($urandom_range(0, 4));
    end
    capture();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/id_stage_hazard_pipe.md
Name: id_stage_hazard_pipe

Overview:
Parametrised decode stage with an integrated hazard unit and ID/EX pipeline register. It decodes ARM data-processing, LDR/STR and B instructions, reads a REG_COUNT-entry register file, evaluates the condition field against the status flags, and detects RAW hazards against EX and MEM. It inserts bubbles on hazards and registers all EX-bound fields with flush, freeze and valid tracking. It sits between the IF/ID register and the EX stage.

Parameters:
DATA_WIDTH, 32, register and operand width
ADDR_WIDTH, 32, PC width
REG_COUNT, 16, register file entries (power of 2, >=16); RA = log2(REG_COUNT)
FORWARD_EN, 0, 0: stall on any RAW with EX/MEM; 1: stall only on load-use with EX
RF_BYPASS, 1, 1: a read of wb_dest in the same cycle returns wb_result

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
flush  in  1  branch taken in EX; kill the instruction being registered
freeze  in  1  memory stall; ID/EX register holds
valid_in  in  1  IF/ID holds a real instruction
pc_in  in  ADDR_WIDTH  PC+4 of the instruction
instruction  in  32  instruction word
sr  in  4  status flags {N,Z,C,V}
wb_en_in  in  1  register file write enable
wb_dest  in  RA  write address
wb_result  in  DATA_WIDTH  write data
ex_wb_en, ex_mem_r_en  in  1 each  EX-stage control
ex_dest  in  RA  EX destination
mem_wb_en  in  1  MEM-stage write enable
mem_dest  in  RA  MEM destination
hazard_stall  out  1  combinational; hold PC and IF/ID
valid_out, wb_en_out, mem_r_en, mem_w_en, b, s, imm  out  1 each  registered controls
exec_cmd  out  4  ALU command
pc_out  out  ADDR_WIDTH  registered PC
val_r_n, val_r_m  out  DATA_WIDTH  operand values
shift_operand  out  12  instr[11:0]
signed_imm_24  out  24  instr[23:0]
dest, src_1, src_2  out  RA  register addresses for the forwarding unit

Behaviour:
- Reset (rst=0, asynchronous): all registered outputs are 0; all register file entries are 0.
- Fields: cond [31:28], mode [27:26], I [25], op [24:21], S [20], Rn [19:16], Rd [15:12].
- Mode 00 exec_cmd: MOV 1101->0001, MVN 1111->1001, ADD 0100->0010, ADC 0101->0011, SUB 0010->0100, SBC 0110->0101, AND 0000->0110, ORR 1100->0111, EOR 0001->1000, CMP 1010->0100, TST 1000->0110.
- Mode 00 wb_en: 1 except CMP and TST.
- Mode 01: LDR when S=1 (mem_r_en=1, wb_en=1, exec_cmd=0010); STR when S=0 (mem_w_en=1, exec_cmd=0010).
- Mode 10: b=1. Undefined encodings produce all controls 0.
- Condition codes: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL per ARM; 1111 is treated as never.
- A failed condition zeroes wb_en, mem_r_en, mem_w_en, b and s.
- Sources: src_1=Rn; src_2=Rd for STR, else instr[3:0].
- two_src = (I=0 in mode 00) or STR. MOV and MVN do not use Rn; B uses no sources.
- Hazard, FORWARD_EN=0: hazard_stall=1 when valid_in and a used source equals ex_dest with ex_wb_en, or equals mem_dest with mem_wb_en.
- Hazard, FORWARD_EN=1: hazard_stall=1 only when ex_mem_r_en and a used source equals ex_dest.
- Hazard evaluation is combinational, with no latency.
- Register file: write on the rising edge when wb_en_in. With RF_BYPASS=1 a same-cycle read of wb_dest returns wb_result; otherwise it returns the old value.
- ID/EX register update, per edge, in priority order:
  1. freeze=1: hold all outputs. Freeze beats flush; flush is re-asserted by EX while frozen.
  2. flush=1: valid_out=0 and all controls 0.
  3. hazard_stall=1 or valid_in=0: bubble (valid_out=0, controls 0; data fields are don't-care but are loaded).
  4. Otherwise load the decoded values and set valid_out=1.
- Decode-to-EX latency is 1 cycle. A stalled instruction re-decodes every cycle, so a WB write arriving mid-stall is captured.
- Reset asserted mid-stall clears everything immediately; hazard_stall then depends only on inputs.

Test Plan:
- Reset, then ADD R1,R2,R3 with R2=5, R3=7 and no hazards -> next cycle valid_out=1, exec_cmd=0010, val_r_n=5, val_r_m=7, dest=1, wb_en_out=1.
- FORWARD_EN=0, SUB R4,R1,#1 with ex_dest=1, ex_wb_en=1 -> hazard_stall=1 and a bubble is registered; when EX clears, the instruction is issued on the following edge.
- FORWARD_EN=1, same case with ex_mem_r_en=0 -> no stall; with ex_mem_r_en=1 -> stall for one cycle.
- MOVEQ R0,#3 with sr Z=0 -> wb_en_out=0 and valid_out=1; with Z=1 -> wb_en_out=1.
- freeze=1 and flush=1 together for 2 cycles -> outputs unchanged; releasing freeze with flush=1 -> valid_out=0.
- RF_BYPASS=1, wb_en_in=1, wb_dest=2, wb_result=0xDEAD while reading R2 -> val_r_n=0xDEAD next cycle; assert rst=0 mid-pipeline -> all outputs 0 immediately.
